// File: rtl/inst_buffer_pkg.sv
// inst_buffer_pkg: shared INST_PC packet type, RV32 NOOP encoding and default buffer depth
package inst_buffer_pkg;
  localparam int INST_BUF_DEPTH = 8;
  localparam logic [31:0] RV32_NOOP = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] PC;
    logic [31:0] NPC;
  } INST_PC;
  localparam INST_PC NOOP_PACKET = '{inst: RV32_NOOP, PC: 32'h0, NPC: 32'h0};
endpackage

// File: rtl/inst_buffer.sv
// inst_buffer: fetch->decode circular FIFO; ports clock/reset/squash_i, fetch_valid_i/fetch_inst_PC_i/fetch_ready_o push side, decode_ready_i/inst_valid_o/inst_PC_o pop side, count_o occupancy
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = INST_BUF_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             squash_i,
  input  logic             fetch_valid_i,
  input  INST_PC           fetch_inst_PC_i,
  output logic             fetch_ready_o,
  input  logic             decode_ready_i,
  output logic             inst_valid_o,
  output INST_PC           inst_PC_o,
  output logic [CNT_W-1:0] count_o
);
  INST_PC entry [DEPTH];
  logic [PTR_W-1:0] head_ptr, tail_ptr;
  logic [CNT_W-1:0] count;
  logic push, pop;
  assign fetch_ready_o = count != CNT_W'(DEPTH);
  assign inst_valid_o  = count != '0;
  assign count_o       = count;
  assign push = fetch_valid_i & fetch_ready_o & ~squash_i;
  assign pop  = decode_ready_i & inst_valid_o & ~squash_i;
  always_ff @(posedge clock) begin
    if (reset || squash_i) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + PTR_W'(1);
      if (pop) head_ptr <= head_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end
  always_ff @(posedge clock) begin
    if (push) entry[tail_ptr] <= fetch_inst_PC_i;
  end
  always_comb begin
    inst_PC_o = inst_valid_o ? entry[head_ptr] : NOOP_PACKET;
  end
endmodule

// File: tb/tb_inst_buffer.sv
// tb_inst_buffer: scoreboard-driven self-checking bench for inst_buffer
module tb_inst_buffer;
  import inst_buffer_pkg::*;
  logic clock = 1'b0;
  logic reset, squash_i, fetch_valid_i, decode_ready_i;
  logic fetch_ready_o, inst_valid_o;
  INST_PC fetch_inst_PC_i, inst_PC_o;
  logic [3:0] count_o;
  INST_PC sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  inst_buffer dut (
    .clock(clock), .reset(reset), .squash_i(squash_i),
    .fetch_valid_i(fetch_valid_i), .fetch_inst_PC_i(fetch_inst_PC_i), .fetch_ready_o(fetch_ready_o),
    .decode_ready_i(decode_ready_i), .inst_valid_o(inst_valid_o), .inst_PC_o(inst_PC_o),
    .count_o(count_o)
  );

  always #5 clock = ~clock;

  function automatic INST_PC mk(input logic [31:0] pc);
    return '{inst: 32'h0000_0093 | (pc << 12), PC: pc, NPC: pc + 32'd4};
  endfunction

  task automatic tick(input logic fv, input logic [31:0] pc, input logic dr, input logic sq);
    logic pu, po;
    fetch_valid_i = fv;
    fetch_inst_PC_i = mk(pc);
    decode_ready_i = dr;
    squash_i = sq;
    pu = fv && sb.size() < 8 && !sq;
    po = dr && sb.size() > 0 && !sq;
    @(posedge clock);
    #1;
    if (sq) sb.delete();
    else begin
      if (po) void'(sb.pop_front());
      if (pu) sb.push_back(mk(pc));
    end
    fetch_valid_i = 1'b0;
    decode_ready_i = 1'b0;
    squash_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    squash_i = 1'b0;
    fetch_valid_i = 1'b0;
    decode_ready_i = 1'b0;
    fetch_inst_PC_i = mk(32'h0);
    repeat (2) @(posedge clock);
    #1;
    sb.delete();
    n_cmp++; if (inst_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", inst_valid_o); end
    n_cmp++; if (fetch_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", fetch_ready_o); end
    n_cmp++; if (count_o !== 4'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", count_o); end
    n_cmp++; if (inst_PC_o !== NOOP_PACKET) begin n_bad++; $display("FAIL reset_noop got %h want %h", inst_PC_o, NOOP_PACKET); end
    reset = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) tick(1'b1, 32'(i * 4), 1'b0, 1'b0);
    n_cmp++; if (count_o !== 4'd8) begin n_bad++; $display("FAIL fill_count got %0d want 8", count_o); end
    n_cmp++; if (fetch_ready_o !== 1'b0) begin n_bad++; $display("FAIL fill_ready got %b want 0", fetch_ready_o); end
    tick(1'b1, 32'h20, 1'b0, 1'b0);
    n_cmp++; if (count_o !== 4'd8) begin n_bad++; $display("FAIL ninth_count got %0d want 8", count_o); end
    n_cmp++; if (inst_PC_o.PC !== 32'h0) begin n_bad++; $display("FAIL ninth_head got %h want 0", inst_PC_o.PC); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (inst_PC_o.PC !== 32'(i * 4)) begin n_bad++; $display("FAIL drain_pc[%0d] got %h want %h", i, inst_PC_o.PC, i * 4); end
      n_cmp++; if (inst_PC_o !== sb[0]) begin n_bad++; $display("FAIL drain_pkt[%0d] got %h want %h", i, inst_PC_o, sb[0]); end
      tick(1'b0, 32'h0, 1'b1, 1'b0);
    end
    n_cmp++; if (inst_valid_o !== 1'b0) begin n_bad++; $display("FAIL drain_empty got %b want 0", inst_valid_o); end
    n_cmp++; if (inst_PC_o !== NOOP_PACKET) begin n_bad++; $display("FAIL drain_noop got %h want %h", inst_PC_o, NOOP_PACKET); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 3; i++) tick(1'b1, 32'h100 + 32'(i * 4), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      n_cmp++; if (inst_PC_o.PC !== 32'h100 + 32'(i * 4) || inst_PC_o !== sb[0]) begin n_bad++; $display("FAIL stream_pc[%0d] got %h want %h", i, inst_PC_o.PC, 32'h100 + 32'(i * 4)); end
      tick(1'b1, 32'h100 + 32'((i + 3) * 4), 1'b1, 1'b0);
      n_cmp++; if (count_o !== 4'd3) begin n_bad++; $display("FAIL stream_count[%0d] got %0d want 3", i, count_o); end
    end
    for (int i = 20; i < 23; i++) begin
      n_cmp++; if (inst_PC_o.PC !== 32'h100 + 32'(i * 4)) begin n_bad++; $display("FAIL stream_tail[%0d] got %h want %h", i, inst_PC_o.PC, 32'h100 + 32'(i * 4)); end
      tick(1'b0, 32'h0, 1'b1, 1'b0);
    end
    n_cmp++; if (count_o !== 4'd0) begin n_bad++; $display("FAIL stream_end got %0d want 0", count_o); end
  endtask

  task automatic test_squash();
    for (int i = 0; i < 5; i++) tick(1'b1, 32'h200 + 32'(i * 4), 1'b0, 1'b0);
    n_cmp++; if (count_o !== 4'd5) begin n_bad++; $display("FAIL squash_pre got %0d want 5", count_o); end
    tick(1'b1, 32'h300, 1'b1, 1'b1);
    n_cmp++; if (count_o !== 4'd0) begin n_bad++; $display("FAIL squash_count got %0d want 0", count_o); end
    n_cmp++; if (inst_valid_o !== 1'b0) begin n_bad++; $display("FAIL squash_valid got %b want 0", inst_valid_o); end
    tick(1'b1, 32'h400, 1'b0, 1'b0);
    n_cmp++; if (count_o !== 4'd1 || inst_PC_o !== sb[0] || inst_PC_o.PC !== 32'h400) begin n_bad++; $display("FAIL squash_after got cnt=%0d pc=%h want cnt=1 pc=400", count_o, inst_PC_o.PC); end
    tick(1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic test_latency();
    fetch_valid_i = 1'b1;
    fetch_inst_PC_i = mk(32'h40);
    #1;
    n_cmp++; if (inst_valid_o !== 1'b0) begin n_bad++; $display("FAIL lat_same got %b want 0", inst_valid_o); end
    tick(1'b1, 32'h40, 1'b0, 1'b0);
    n_cmp++; if (inst_valid_o !== 1'b1 || inst_PC_o.PC !== 32'h40) begin n_bad++; $display("FAIL lat_next got v=%b pc=%h want v=1 pc=40", inst_valid_o, inst_PC_o.PC); end
    tick(1'b0, 32'h0, 1'b1, 1'b0);
    tick(1'b0, 32'h0, 1'b1, 1'b0);
    n_cmp++; if (count_o !== 4'd0 || inst_valid_o !== 1'b0) begin n_bad++; $display("FAIL empty_pop got cnt=%0d v=%b want 0/0", count_o, inst_valid_o); end
  endtask

  task automatic test_reset_mid();
    tick(1'b1, 32'h500, 1'b0, 1'b0);
    tick(1'b1, 32'h504, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    sb.delete();
    n_cmp++; if (count_o !== 4'd0 || inst_PC_o !== NOOP_PACKET) begin n_bad++; $display("FAIL reset_mid got cnt=%0d pkt=%h want 0/noop", count_o, inst_PC_o); end
    tick(1'b1, 32'h600, 1'b0, 1'b0);
    n_cmp++; if (inst_PC_o.PC !== 32'h600) begin n_bad++; $display("FAIL reset_mid_push got %h want 600", inst_PC_o.PC); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_stream();
    test_squash();
    test_latency();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
